// File: rtl/round_key_sequencer.sv
// round_key_sequencer: serves one 128-bit round key per rk_valid/rk_ready handshake from a snapshot of the expanded key.
// Ports: clk, rst (sync, active low); start/decrypt/keySize sampled in IDLE; keyExp flat expanded key (round i at [128*i +: 128]);
// abort ends the sequence without done; rk/rk_index/rk_last/rk_valid present the key; busy while running; done pulses after the last transfer.
// Build option: ROUNDKEY_ZEROIZE_EN clears snapshot, rk and rk_index on completion and on abort.
module round_key_sequencer #(
  parameter int KEY_BITS = 1920,
  parameter int RK_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [2:0]          keySize,
  input  logic [0:KEY_BITS-1] keyExp,
  input  logic                abort,
  input  logic                rk_ready,
  output logic                rk_valid,
  output logic [0:RK_BITS-1]  rk,
  output logic [3:0]          rk_index,
  output logic                rk_last,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;
  logic [0:KEY_BITS-1] snap;
  logic [3:0] nr, nr_in, first, nxt;
  logic dec;
  always_comb begin
    nr_in = keySize == 3'b010 ? 4'd12 : keySize == 3'b100 ? 4'd14 : 4'd10;
    first = decrypt ? nr_in : 4'd0;
    nxt = dec ? rk_index - 4'd1 : rk_index + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      snap <= '0;
      nr <= '0;
      dec <= 1'b0;
      rk_valid <= 1'b0;
      rk <= '0;
      rk_index <= '0;
      rk_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap <= keyExp;
          nr <= nr_in;
          dec <= decrypt;
          rk_index <= first;
          // snapshot is not loaded yet, so the first key comes straight off the bus
          rk <= keyExp[RK_BITS*first +: RK_BITS];
          rk_last <= 1'b0;
          rk_valid <= 1'b1;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (abort) begin
          rk_valid <= 1'b0;
          rk_last <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
`ifdef ROUNDKEY_ZEROIZE_EN
          snap <= '0;
          rk <= '0;
          rk_index <= '0;
`endif
        end else if (rk_ready) begin
          if (rk_last) begin
            rk_valid <= 1'b0;
            rk_last <= 1'b0;
            done <= 1'b1;
            state <= DONE;
`ifdef ROUNDKEY_ZEROIZE_EN
            snap <= '0;
            rk <= '0;
            rk_index <= '0;
`endif
          end else begin
            rk_index <= nxt;
            rk <= snap[RK_BITS*nxt +: RK_BITS];
            rk_last <= dec ? nxt == 4'd0 : nxt == nr;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: scoreboard bench for round_key_sequencer with a queue-based reference model.
module tb_round_key_sequencer;
  logic clk = 0, rst = 0, start = 0, decrypt = 0, abort = 0, rk_ready = 0;
  logic [2:0] keySize = '0;
  logic [0:1919] keyExp = '0, kexp = '0;
  logic rk_valid, rk_last, busy, done;
  logic [0:127] rk;
  logic [3:0] rk_index;
  localparam logic [127:0] RK0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] RK12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  typedef struct {logic [127:0] key; logic [3:0] idx; logic last;} exp_t;
  exp_t exp_q[$];
  int checks = 0, fails = 0, xfers = 0, done_cnt = 0;
  bit done_due = 0, prev_stall = 0, got_first = 0;
  logic [127:0] prev_rk, first_rk, last_rk;
  logic [3:0] prev_idx, first_idx, last_idx;

  always #5 clk = ~clk;

  round_key_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .keySize(keySize),
    .keyExp(keyExp), .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid),
    .rk(rk), .rk_index(rk_index), .rk_last(rk_last), .busy(busy), .done(done)
  );

  function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endfunction

  function automatic int nr_of(logic [2:0] ks);
    return ks == 3'b010 ? 12 : ks == 3'b100 ? 14 : 10;
  endfunction

  // expected key stream: Nr+1 slices of the expanded key, ascending or descending
  function automatic void model(logic [2:0] ks, logic d, logic [0:1919] k);
    int nr = nr_of(ks);
    for (int j = 0; j <= nr; j++) begin
      int r = d ? nr - j : j;
      exp_t e;
      e.key = k[128*r +: 128];
      e.idx = 4'(r);
      e.last = (j == nr);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        chk("stall_rk", rk, prev_rk);
        chk("stall_idx", rk_index, prev_idx);
        chk("stall_valid", rk_valid, 1);
      end
      if (done_due) begin
        chk("done_pulse", done, 1);
        chk("done_valid_low", rk_valid, 0);
        done_due = 0;
      end else if (done) chk("unexpected_done", done, 0);
      if (done) done_cnt++;
      if (rk_valid && rk_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_xfer: got transfer of index %0d, expected none", rk_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rk", rk, e.key);
          chk("rk_index", rk_index, e.idx);
          chk("rk_last", rk_last, e.last);
          if (e.last) done_due = 1;
          xfers++;
          if (!got_first) begin
            first_rk = rk;
            first_idx = rk_index;
            got_first = 1;
          end
          last_rk = rk;
          last_idx = rk_index;
        end
      end
      prev_stall = rk_valid && !rk_ready && !abort;
      prev_rk = rk;
      prev_idx = rk_index;
    end else begin
      prev_stall = 0;
      done_due = 0;
    end
  end

  task automatic kick(input logic [2:0] ks, input logic d);
    keySize = ks;
    decrypt = d;
    keyExp = kexp;
    start = 1;
    got_first = 0;
    model(ks, d, kexp);
    @(posedge clk) #1;
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_seq(input logic [2:0] ks, input logic d, input int mode, input bit clobber, input bit hold);
    int d0 = done_cnt, x0 = xfers, k = 0;
    kick(ks, d);
    chk("latency_valid", rk_valid, 1);
    chk("busy", busy, 1);
    if (!hold) start = 0;
    if (clobber) begin
      keyExp = '1;
      keySize = ~ks;
      decrypt = ~d;
    end
    while (done_cnt == d0 && k < 200) begin
      rk_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      @(posedge clk) #1;
      k++;
    end
    if (done_cnt == d0) chk("seq_timeout", done_cnt, d0 + 1);
    start = 0;
    rk_ready = 0;
    chk("xfer_count", xfers - x0, nr_of(ks) + 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int k = 0;
    rk_ready = 1;
    while (!(rk_valid && rk_index == target) && k < 50) begin
      @(posedge clk) #1;
      k++;
    end
    if (k >= 50) chk("wait_idx_timeout", rk_index, target);
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", rk_valid, 0);
    chk("reset_rk", rk, 0);
    chk("reset_idx", rk_index, 0);
    chk("reset_last", rk_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1;
    for (int i = 0; i < 15; i++) kexp[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    kexp[0 +: 128] = RK0;
    kexp[1280 +: 128] = RK10;
    kexp[1536 +: 128] = RK12;
    kexp[1792 +: 128] = RK14;
    @(posedge clk) #1;

    run_seq(3'b000, 0, 0, 0, 0);
    chk("aes128_first_rk", first_rk, RK0);
    chk("aes128_first_idx", first_idx, 0);
    chk("aes128_last_rk", last_rk, RK10);
    chk("aes128_last_idx", last_idx, 10);

    run_seq(3'b100, 1, 0, 0, 0);
    chk("aes256_first_rk", first_rk, RK14);
    chk("aes256_first_idx", first_idx, 14);
    chk("aes256_last_rk", last_rk, RK0);
    chk("aes256_last_idx", last_idx, 0);

    run_seq(3'b010, 0, 1, 0, 0);
    chk("aes192_last_rk", last_rk, RK12);
    chk("aes192_last_idx", last_idx, 12);

    run_seq(3'b000, 0, 2, 1, 0);
    chk("isolated_last_rk", last_rk, RK10);

    d0 = done_cnt;
    kick(3'b000, 0);
    start = 0;
    wait_idx(4'd5);
    abort = 1;
    @(posedge clk) #1;
    abort = 0;
    rk_ready = 0;
    exp_q.delete();
    chk("abort_valid", rk_valid, 0);
    chk("abort_busy", busy, 0);
`ifdef ROUNDKEY_ZEROIZE_EN
    chk("abort_zero_rk", rk, 0);
    chk("abort_zero_idx", rk_index, 0);
`endif
    repeat (3) @(posedge clk) #1;
    chk("abort_no_done", done_cnt, d0);

    run_seq(3'b000, 0, 0, 0, 0);
    chk("post_abort_first_idx", first_idx, 0);
    chk("post_abort_first_rk", first_rk, RK0);

    run_seq(3'b010, 1, 2, 0, 1);

    kick(3'b000, 0);
    start = 0;
    wait_idx(4'd3);
    rst = 0;
    @(posedge clk) #1;
    chk("mid_reset_valid", rk_valid, 0);
    chk("mid_reset_rk", rk, 0);
    chk("mid_reset_idx", rk_index, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_last", rk_last, 0);
    rst = 1;
    rk_ready = 0;
    exp_q.delete();
    @(posedge clk) #1;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 15; i++) kexp[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      run_seq(3'($urandom), 1'($urandom), 2, t % 2, 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Consumer end of the expanded-key bus: takes the flat expanded key from key expansion and serves one 128-bit round key per handshake to the cipher round datapath.
- Order is forward (encrypt, round 0..Nr) or reverse (decrypt, round Nr..0).
- Snapshots the expanded key at start, so key expansion may be re-triggered while a sequence is in flight.

Parameters:
- KEY_BITS, 1920, width of the expanded-key bus (15 round keys x 128 bits).
- RK_BITS, 128, width of one round key.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active low.
- start  input  1  begin a sequence; sampled only in IDLE.
- decrypt  input  1  0 = forward order, 1 = reverse order; sampled with start.
- keySize  input  3  3'b010 = AES-192 (Nr=12), 3'b100 = AES-256 (Nr=14), any other value = AES-128 (Nr=10); sampled with start.
- keyExp  input  [0:1919]  expanded key; round key i occupies bits [128*i : 128*i+127], MSB-first.
- abort  input  1  terminate the current sequence.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk_valid  output  1  rk is valid.
- rk  output  [0:127]  current round key.
- rk_index  output  4  round number of rk (0..14).
- rk_last  output  1  rk is the final key of the sequence.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; rk_valid=0, rk=0, rk_index=0, rk_last=0, busy=0, done=0; snapshot registers cleared. Reset overrides every other input, including mid-sequence.
- Nr and round-key count: Nr decoded from keySize as above; round keys per sequence = Nr+1.
- Transfer: occurs on any clk edge with rk_valid && rk_ready.
- State machine, 3 states:
  - IDLE: busy=0, rk_valid=0. On start=1: capture keyExp into a 1920-bit snapshot, latch Nr and decrypt, set rk_index to 0 (forward) or Nr (reverse), go to ISSUE. The first rk_valid appears the cycle after start (latency 1).
  - ISSUE: busy=1, rk_valid=1, rk = snapshot[128*rk_index +: 128], rk_last=1 when rk_index is Nr (forward) or 0 (reverse).
    - Transfer, not last: rk_index increments (forward) or decrements (reverse); stay in ISSUE. Back-to-back transfers give one key per cycle.
    - Transfer on last key: go to DONE.
    - rk_ready=0: rk, rk_index and rk_valid hold stable (no drop, no change while stalled).
    - abort=1: go to IDLE next cycle, rk_valid=0, no done pulse. abort has priority over a simultaneous transfer.
  - DONE: done=1 for exactly one cycle, rk_valid=0, busy=1; then IDLE.
- start outside IDLE is ignored, including in DONE. A new start is accepted no earlier than the cycle after DONE.
- Changes to keyExp, keySize or decrypt after start have no effect on the running sequence.
- rk_index never wraps: no index beyond Nr is produced forward, none below 0 in reverse.
- Snapshot bits beyond round Nr are captured but never output.
- rk and rk_index hold their last values in IDLE/DONE, unless ROUNDKEY_ZEROIZE_EN is defined.

Optional Feature:
- Macro ROUNDKEY_ZEROIZE_EN.
- Defined: on entry to DONE, and on abort, the snapshot, rk and rk_index are cleared to 0 in the same edge. rk reads 0 in DONE/IDLE, so no key material lingers.
- Undefined: snapshot and rk retain the last values until the next start or reset.

Test Plan:
- AES-128 forward, rk_ready=1 constant, keyExp = FIPS-197 expansion of key 000102..0f:
  - 11 consecutive transfers.
  - Index 0: rk=000102030405060708090a0b0c0d0e0f. Index 10: rk=13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
  - done pulses the cycle after the last transfer.
- AES-256 reverse (keySize=3'b100, decrypt=1):
  - First rk_index=14, rk=24fc79ccbf0979e9371ac23c6d68de36.
  - Last rk_index=0, rk=000102030405060708090a0b0c0d0e0f; 15 transfers total.
- AES-192 forward with rk_ready toggling 1,0,0,1,...:
  - rk stable during stalls; index 12 = a4970a331a78dc09c418c271e3a41d5d.
  - Exactly 13 transfers, none duplicated.
- Snapshot isolation: keyExp forced to all-ones one cycle after start -> all returned keys still match the FIPS values.
- abort asserted at rk_index=5 -> rk_valid=0 next cycle, no done pulse, IDLE.
  - A following start runs a full sequence from index 0.
  - With ROUNDKEY_ZEROIZE_EN, rk=0 after the abort.
- Start held high during ISSUE is ignored. rst=0 at rk_index=3 -> all outputs 0 next cycle, state IDLE.
